// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, FSM state type and the 64-bit result type.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef logic [63:0] md_res_t;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div/accumulate datapath. Produces the {hi,lo} result for
// the op on its inputs; div_zero flags a divide whose divisor is zero.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] sx_rs, sx_rt, sprod;
  logic signed [31:0] s_rs, s_rt;
  md_res_t            res;

  assign sx_rs = {{32{rs_val[31]}}, rs_val};
  assign sx_rt = {{32{rt_val[31]}}, rt_val};
  assign sprod = sx_rs * sx_rt;
  assign s_rs  = rs_val;
  assign s_rt  = rt_val;

  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (md_op_e'(md_op))
      MD_MULT:  res = sprod;
      MD_MULTU: res = {32'h0, rs_val} * {32'h0, rt_val};
      MD_DIV: begin
        if (rt_val == '0) begin
          div_zero = 1'b1;
        // The one overflowing signed quotient is pinned rather than left to the divider.
        end else if (rs_val == 32'h8000_0000 && rt_val == '1) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          res = {32'(s_rs % s_rt), 32'(s_rs / s_rt)};
        end
      end
      MD_DIVU: begin
        if (rt_val == '0) div_zero = 1'b1;
        else              res = {rs_val % rt_val, rs_val / rt_val};
      end
      MD_MADD:  res = {hi, lo} + sprod;
      MD_MSUB:  res = {hi, lo} - sprod;
      default:  res = '0;
    endcase
  end

  assign res_hi = res[63:32];
  assign res_lo = res[31:0];

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding HI/LO. Long ops stage their result in
// pend_* and commit after the busy period. MDU_MADD_EN enables madd/msub.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_active,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [31:0] pend_hi_q, pend_lo_q, hi_q, lo_q;
  logic        pend_dz_q, busy_q;
  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  md_arith u_arith (
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hi       (hi_q),
    .lo       (lo_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (md_op_e'(md_op))
              MD_MULT, MD_MULTU: begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_dz_q <= 1'b0;
                cnt_q     <= MULT_CNT;
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
`ifdef MDU_MADD_EN
              MD_MADD, MD_MSUB: begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_dz_q <= 1'b0;
                cnt_q     <= MULT_CNT;
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
`endif
              MD_DIV, MD_DIVU: begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                pend_dz_q <= div_zero;
                cnt_q     <= DIV_CNT;
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
              MD_MTHI: hi_q <= rs_val;
              MD_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // A divide by zero still runs its full busy period, then skips the commit.
          if (cnt_q == 4'd1) begin
            if (!pend_dz_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign md_active = start | busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed plan cases plus randomized ops
// against an arithmetic reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, md_active;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .md_active (md_active),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n === 1'b1)
      assert (!(start === 1'b1 && busy === 1'b1)) else $error("start issued while busy");

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void model(input logic [2:0] op, input logic [31:0] a, b,
                                input logic [31:0] h, l,
                                output logic [31:0] nh, nl, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    nh = h; nl = l; lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); {nh, nl} = p; lat = MC; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; {nh, nl} = p; lat = MC; end
      3'd2: begin
        lat = DC;
        if (b != 0) begin
          q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
          if ((sa < 0) != (sb < 0)) q = -q;
          r = sa - q * sb;
          nl = q[31:0]; nh = r[31:0];
        end
      end
      3'd3: begin
        lat = DC;
        if (b != 0) begin
          q = longint'({32'h0, a}) / longint'({32'h0, b});
          r = longint'({32'h0, a}) - q * longint'({32'h0, b});
          nl = q[31:0]; nh = r[31:0];
        end
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: begin
`ifdef MDU_MADD_EN
        p = 64'(sa * sb);
        acc = (op == 3'd6) ? ({h, l} + p) : ({h, l} - p);
        {nh, nl} = acc;
        lat = MC;
`else
        p = '0; acc = '0;
`endif
      end
    endcase
  endfunction

  // Drives one op for a single cycle (caller sits at a negedge) and returns at
  // the negedge of the first cycle with busy low, reporting how long busy was
  // held and whether hi/lo stayed put meanwhile.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b,
                       output int nbusy, output logic stable);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    nbusy = 0; stable = 1'b1;
    while (busy === 1'b1 && nbusy < 40) begin
      nbusy++;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
    start = 1'b1; #1;
    checks++; if (md_active !== 1'b1) begin errors++; $display("FAIL md_active_start got %b exp 1", md_active); end
    start = 1'b0; #1;
    checks++; if (md_active !== 1'b0) begin errors++; $display("FAIL md_active_idle got %b exp 0", md_active); end
    @(negedge clk); rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int nb; logic st;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, nb, st);
    checks++; if (nb != MC) begin errors++; $display("FAIL mult_busy got %0d exp %0d", nb, MC); end
    checks++; if (!st) begin errors++; $display("FAIL mult_hold got changed exp stable"); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_res got %h/%h exp ffffffff/fffffffa", hi, lo); end
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3, nb, st);
    checks++; if (nb != MC) begin errors++; $display("FAIL multu_busy got %0d exp %0d", nb, MC); end
    checks++; if (!st) begin errors++; $display("FAIL multu_hold got changed exp stable"); end
    checks++; if (hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_res got %h/%h exp 00000002/fffffffa", hi, lo); end
  endtask

  task automatic test_div;
    int nb; logic st;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, nb, st);
    checks++; if (nb != DC) begin errors++; $display("FAIL div_busy got %0d exp %0d", nb, DC); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_res got %h/%h exp ffffffff/fffffffd", hi, lo); end
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd0, nb, st);
    checks++; if (nb != DC) begin errors++; $display("FAIL div0_busy got %0d exp %0d", nb, DC); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div0_hold got %h/%h exp ffffffff/fffffffd", hi, lo); end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, st);
    checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h/%h exp 00000000/80000000", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int nb; logic st;
    issue(MD_MTHI, 32'h1234_5678, 32'h0, nb, st);
    checks++; if (nb != 0) begin errors++; $display("FAIL mthi_busy got %0d exp 0", nb); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    issue(MD_MULT, 32'd6, 32'd7, nb, st);
    issue(MD_DIVU, 32'd100, 32'd7, nb, st);
    checks++; if (nb != DC) begin errors++; $display("FAIL b2b_busy got %0d exp %0d", nb, DC); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_divu got %h/%h exp 00000002/0000000e", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int bad;
    start = 1'b1; md_op = MD_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_mid got busy=%b %h/%h exp 0 0/0", busy, hi, lo); end
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (DC + 4) begin @(negedge clk); if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_no_commit got %0d bad cycles exp 0", bad); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_madd;
    int nb; logic st;
    issue(MD_MTHI, 32'h0, 32'h0, nb, st);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'h0, nb, st);
`ifdef MDU_MADD_EN
    issue(MD_MADD, 32'd1, 32'd1, nb, st);
    checks++; if (nb != MC) begin errors++; $display("FAIL madd_busy got %0d exp %0d", nb, MC); end
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL madd_res got %h/%h exp 00000001/00000000", hi, lo); end
    m_hi = 32'h1; m_lo = 32'h0;
`else
    issue(MD_MADD, 32'd1, 32'd1, nb, st);
    checks++; if (nb != 0) begin errors++; $display("FAIL op6_busy got %0d exp 0", nb); end
    checks++; if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL op6_nochange got %h/%h exp 00000000/ffffffff", hi, lo); end
    m_hi = 32'h0; m_lo = 32'hFFFF_FFFF;
`endif
  endtask

  task automatic test_random;
    int nb, lat; logic st;
    logic [2:0] op; logic [31:0] a, b, eh, el;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(op, a, b, m_hi, m_lo, eh, el, lat);
      issue(op, a, b, nb, st);
      checks++; if (nb != lat) begin errors++; $display("FAIL rand_busy[%0d] op=%0d got %0d exp %0d", i, op, nb, lat); end
      checks++; if (!st) begin errors++; $display("FAIL rand_hold[%0d] op=%0d got changed exp stable", i, op); end
      checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL rand_res[%0d] op=%0d a=%h b=%h got %h/%h exp %h/%h", i, op, a, b, hi, lo, eh, el); end
      m_hi = eh; m_lo = el;
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
